inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Write side of instruction memory. Accepts a stream of W-bit machine-code words
//  over a valid/ready handshake and writes them to consecutive addresses of the
//  instruction RAM. The fetch path reads that RAM by InstAddress.
//  Holds the CPU in reset-hold (CpuHold) while loading.
//  Releases the CPU when the last word is written.
// PARAMETERS
//  A      16    instruction address width (matches fetch-side InstAddress)
//  W      9     instruction word width (matches fetch-side InstOut)
//  DEPTH  1024  number of writable words; must satisfy 1 <= DEPTH <= 2**A
// PORTS
//  Clk        in   1    clock; all logic on rising edge
//  Reset_n    in   1    asynchronous, active-low reset
//  Start      in   1    1-cycle pulse; begins a load at address 0
//  InData     in   W    instruction word
//  InValid    in   1    InData valid
//  InLast     in   1    qualifies the final word of the image; sampled with InValid
//  InReady    out  1    loader can accept a word this cycle
//  WrEn       out  1    RAM write strobe
//  WrAddr     out  A    RAM write address
//  WrData     out  W    RAM write data
//  CpuHold    out  1    high while loading; the CPU must not fetch
//  Done       out  1    level; image loaded; cleared by the next Start
//  Error      out  1    level; overflow or checksum fail; cleared by the next Start
//  WordCount  out  A+1  words written in the current/last load
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; every output 0; addr/count=0.
//  Handshake: a beat transfers when InValid && InReady.
//   - InReady is combinational from state (1 only in LOAD, and in CHECK when enabled).
//   - InData/InValid/InLast are don't-care when not transferred.
//  FSM IDLE -> LOAD -> [CHECK] -> DONE.
//  IDLE: Start -> LOAD; set addr=0, count=0, CpuHold=1, Done=0, Error=0.
//  LOAD: each beat registers WrEn=1, WrAddr=addr, WrData=InData on the next edge.
//   - Write latency is 1 cycle after the transfer; WrEn is otherwise 0.
//   - On each beat, addr and count increment.
//   - Back-to-back beats give one write per cycle. Gaps in InValid give no writes.
//   - Beat with InLast=1 -> DONE (or CHECK if the checksum feature is compiled in).
//   - Beat at addr==DEPTH-1 with InLast=0 -> word written, Error=1, go to DONE.
//     Addr never wraps.
//   - InLast on the word at DEPTH-1 is a legal full image (no Error).
//  DONE: CpuHold=0, Done=1, InReady=0; WordCount holds. Start -> re-enter LOAD as from IDLE.
//  Start in LOAD/CHECK is ignored. Start coincident with Reset_n low: reset wins.
//  Reset mid-load: immediate return to IDLE, outputs 0; words already written stay in
//  RAM; Done is not set.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//   - Running XOR of all data words is kept.
//   - After the InLast beat: CHECK state, InReady=1; the next beat is a checksum word,
//     not written and not counted.
//   - Mismatch -> Error=1. Either outcome -> DONE.
//   - Overflow path skips CHECK.
//  LOADER_CHECKSUM_EN undefined: no CHECK state, no XOR register; InLast goes straight to DONE.
// STRUCTURE
//  Shared package inst_mem_pkg:
//   - loader_state_t enum {IDLE, LOAD, CHECK, DONE};
//   - INST_A=16 and INST_W=9 constants, shared with the fetch-side memory.
//  Single module; no sub-module needed. The checksum is a W-bit XOR register inside
//  the macro guard.
// TESTING
//  1 Start, beats 9'h0FF, 9'h100, 9'h1FF (last):
//    - WrEn at addr 0,1,2 one cycle after each beat;
//    - Done=1, CpuHold=0, WordCount=3, Error=0.
//  2 InValid toggles 1,0,0,1 with 2 words:
//    - exactly 2 writes, addr 0 and 1, no WrEn in the gap cycles.
//  3 DEPTH=4, send 5 words, none last:
//    - writes addr 0..3, Error=1, Done=1 after word 4;
//    - InReady=0, 5th word not accepted.
//  4 Reset_n low after 2 of 4 words:
//    - all outputs 0 same cycle, state IDLE;
//    - a new Start reloads from addr 0.
//  5 Start pulsed during LOAD: ignored, addr sequence uninterrupted.
//    Start in DONE: Done/Error clear, new load at addr 0.
//  6 (LOADER_CHECKSUM_EN) words 9'h003, 9'h005 (last), checksum 9'h006 -> Error=0;
//    repeat with checksum 9'h007 -> Error=1; checksum word never written.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory: the geometry that the fetch
// side and the loader both use, and the loader FSM states.
package inst_mem_pkg;

    localparam int unsigned INST_A = 16;
    localparam int unsigned INST_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: streams W-bit words from a valid/ready source into
// consecutive RAM addresses starting at 0, holding the CPU off while loading.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum beat).
import inst_mem_pkg::*;

module inst_mem_loader #(
    parameter int unsigned A     = INST_A,
    parameter int unsigned W     = INST_W,
    parameter int unsigned DEPTH = 1024
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [W-1:0] InData,
    input  logic         InValid,
    input  logic         InLast,
    output logic         InReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         CpuHold,
    output logic         Done,
    output logic         Error,
    output logic [A:0]   WordCount
);

    localparam logic [A-1:0] LAST_ADDR = A'(DEPTH - 1);

    loader_state_t state_q, state_d;
    logic [A-1:0]  addr_q, addr_d;
    logic [A:0]    count_d;
    logic          wr_en_d;
    logic [A-1:0]  wr_addr_d;
    logic [W-1:0]  wr_data_d;
    logic          hold_d, done_d, err_d;
    logic          beat;

`ifdef LOADER_CHECKSUM_EN
    logic [W-1:0]  csum_q, csum_d;
`endif

    // Source may only transfer while a data or checksum word is expected.
`ifdef LOADER_CHECKSUM_EN
    assign InReady = (state_q == LOAD) || (state_q == CHECK);
`else
    assign InReady = (state_q == LOAD);
`endif

    assign beat = InValid && InReady;

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            WordCount <= '0;
            WrEn      <= 1'b0;
            WrAddr    <= '0;
            WrData    <= '0;
            CpuHold   <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            WordCount <= count_d;
            WrEn      <= wr_en_d;
            WrAddr    <= wr_addr_d;
            WrData    <= wr_data_d;
            CpuHold   <= hold_d;
            Done      <= done_d;
            Error     <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // Next-state and next-output logic; addr stops at the final word instead of wrapping.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = WordCount;
        wr_en_d   = 1'b0;
        wr_addr_d = WrAddr;
        wr_data_d = WrData;
        hold_d    = CpuHold;
        done_d    = Done;
        err_d     = Error;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LOAD: begin
                if (beat) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = InData;
                    count_d   = WordCount + (A+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ InData;
`endif
                    if (InLast) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
                        hold_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                        hold_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        addr_d = addr_q + A'(1);
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (beat) begin
                    state_d = DONE;
                    hold_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = (InData != csum_q);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with a 4-word memory so the overflow and
// full-image boundaries are reachable in a few cycles.
module tb_inst_mem_loader;

    localparam int unsigned A = 16;
    localparam int unsigned W = 9;
    localparam int unsigned DEPTH = 4;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic [W-1:0] InData;
    logic         InValid;
    logic         InLast;
    logic         InReady;
    logic         WrEn;
    logic [A-1:0] WrAddr;
    logic [W-1:0] WrData;
    logic         CpuHold;
    logic         Done;
    logic         Error;
    logic [A:0]   WordCount;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_csum;

    inst_mem_loader #(.A(A), .W(W), .DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .InData    (InData),
        .InValid   (InValid),
        .InLast    (InLast),
        .InReady   (InReady),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .CpuHold   (CpuHold),
        .Done      (Done),
        .Error     (Error),
        .WordCount (WordCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " in_ready"}, 32'(InReady), 32'd0);
        chk({tag, " wr_en"},    32'(WrEn),    32'd0);
        chk({tag, " wr_addr"},  32'(WrAddr),  32'd0);
        chk({tag, " wr_data"},  32'(WrData),  32'd0);
        chk({tag, " cpu_hold"}, 32'(CpuHold), 32'd0);
        chk({tag, " done"},     32'(Done),    32'd0);
        chk({tag, " error"},    32'(Error),   32'd0);
        chk({tag, " count"},    32'(WordCount), 32'd0);
    endtask

    task automatic start_load(input string tag);
        Start = 1'b1;
        step();
        Start = 1'b0;
        exp_csum = '0;
        chk({tag, " start hold"},  32'(CpuHold), 32'd1);
        chk({tag, " start done"},  32'(Done),    32'd0);
        chk({tag, " start err"},   32'(Error),   32'd0);
        chk({tag, " start count"}, 32'(WordCount), 32'd0);
        chk({tag, " start ready"}, 32'(InReady), 32'd1);
    endtask

    // One transferred data word; the write must appear right after the edge.
    task automatic send(input string tag, input logic [W-1:0] d, input logic last,
                        input int unsigned exp_addr);
        InValid = 1'b1;
        InData  = d;
        InLast  = last;
        chk({tag, " ready"}, 32'(InReady), 32'd1);
        step();
        InValid = 1'b0;
        InLast  = 1'b0;
        exp_csum = exp_csum ^ d;
        chk({tag, " wr_en"},   32'(WrEn),   32'd1);
        chk({tag, " wr_addr"}, 32'(WrAddr), exp_addr);
        chk({tag, " wr_data"}, 32'(WrData), 32'(d));
    endtask

    // With the checksum feature, the image is closed by a correct checksum beat.
    task automatic close_image(input string tag);
`ifdef LOADER_CHECKSUM_EN
        chk({tag, " check done"},  32'(Done),    32'd0);
        chk({tag, " check ready"}, 32'(InReady), 32'd1);
        InValid = 1'b1;
        InData  = exp_csum;
        step();
        InValid = 1'b0;
        chk({tag, " csum no write"}, 32'(WrEn), 32'd0);
`else
        chk({tag, " no check state"}, 32'(InReady), 32'd0);
`endif
    endtask

    initial begin
        Reset_n = 1'b1;
        Start   = 1'b0;
        InData  = '0;
        InValid = 1'b0;
        InLast  = 1'b0;
        exp_csum = '0;
        #3 Reset_n = 1'b0;
        #9;
        check_idle_outputs("reset");
        Reset_n = 1'b1;
        step();
        check_idle_outputs("idle");

        // Three-word image.
        start_load("t1");
        send("t1 w0", 9'h0FF, 1'b0, 0);
        send("t1 w1", 9'h100, 1'b0, 1);
        send("t1 w2", 9'h1FF, 1'b1, 2);
        close_image("t1");
        chk("t1 done",  32'(Done),      32'd1);
        chk("t1 hold",  32'(CpuHold),   32'd0);
        chk("t1 err",   32'(Error),     32'd0);
        chk("t1 count", 32'(WordCount), 32'd3);
        step();
        chk("t1 idle wr_en", 32'(WrEn),    32'd0);
        chk("t1 ready",      32'(InReady), 32'd0);

        // Gaps in InValid produce no writes.
        start_load("t2");
        send("t2 w0", 9'h0AA, 1'b0, 0);
        step();
        chk("t2 gap1 wr_en", 32'(WrEn), 32'd0);
        step();
        chk("t2 gap2 wr_en", 32'(WrEn), 32'd0);
        send("t2 w1", 9'h155, 1'b1, 1);
        close_image("t2");
        chk("t2 done",  32'(Done),      32'd1);
        chk("t2 count", 32'(WordCount), 32'd2);

        // Overflow: four non-last words fill the memory, fifth is refused.
        start_load("t3");
        send("t3 w0", 9'h011, 1'b0, 0);
        send("t3 w1", 9'h022, 1'b0, 1);
        send("t3 w2", 9'h033, 1'b0, 2);
        send("t3 w3", 9'h044, 1'b0, 3);
        chk("t3 err",   32'(Error),     32'd1);
        chk("t3 done",  32'(Done),      32'd1);
        chk("t3 hold",  32'(CpuHold),   32'd0);
        chk("t3 count", 32'(WordCount), 32'd4);
        InValid = 1'b1;
        InData  = 9'h055;
        chk("t3 w4 ready", 32'(InReady), 32'd0);
        step();
        InValid = 1'b0;
        chk("t3 w4 wr_en", 32'(WrEn),      32'd0);
        chk("t3 w4 count", 32'(WordCount), 32'd4);

        // Start in DONE clears Error; a last word at DEPTH-1 is a legal full image.
        start_load("t5b");
        send("t5b w0", 9'h001, 1'b0, 0);
        send("t5b w1", 9'h002, 1'b0, 1);
        send("t5b w2", 9'h004, 1'b0, 2);
        send("t5b w3", 9'h008, 1'b1, 3);
        close_image("t5b");
        chk("t5b err",   32'(Error),     32'd0);
        chk("t5b done",  32'(Done),      32'd1);
        chk("t5b count", 32'(WordCount), 32'd4);

        // Start during LOAD is ignored.
        start_load("t5a");
        send("t5a w0", 9'h010, 1'b0, 0);
        Start = 1'b1;
        send("t5a w1", 9'h020, 1'b0, 1);
        Start = 1'b0;
        chk("t5a hold", 32'(CpuHold), 32'd1);
        send("t5a w2", 9'h030, 1'b1, 2);
        close_image("t5a");
        chk("t5a done",  32'(Done),      32'd1);
        chk("t5a count", 32'(WordCount), 32'd3);

        // Reset mid-load clears everything at once, then a new load starts at 0.
        start_load("t4");
        send("t4 w0", 9'h0C1, 1'b0, 0);
        send("t4 w1", 9'h0C2, 1'b0, 1);
        Reset_n = 1'b0;
        #1;
        check_idle_outputs("t4 rst");
        Reset_n = 1'b1;
        step();
        chk("t4 post done", 32'(Done), 32'd0);
        start_load("t4r");
        send("t4r w0", 9'h0C3, 1'b0, 0);
        send("t4r w1", 9'h0C4, 1'b1, 1);
        close_image("t4r");
        chk("t4r done", 32'(Done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good then bad; the checksum beat is never written or counted.
        start_load("t6a");
        send("t6a w0", 9'h003, 1'b0, 0);
        send("t6a w1", 9'h005, 1'b1, 1);
        chk("t6a in check", 32'(Done), 32'd0);
        InValid = 1'b1;
        InData  = 9'h006;
        step();
        InValid = 1'b0;
        chk("t6a wr_en", 32'(WrEn),      32'd0);
        chk("t6a err",   32'(Error),     32'd0);
        chk("t6a done",  32'(Done),      32'd1);
        chk("t6a count", 32'(WordCount), 32'd2);
        start_load("t6b");
        send("t6b w0", 9'h003, 1'b0, 0);
        send("t6b w1", 9'h005, 1'b1, 1);
        InValid = 1'b1;
        InData  = 9'h007;
        step();
        InValid = 1'b0;
        chk("t6b wr_en", 32'(WrEn),      32'd0);
        chk("t6b err",   32'(Error),     32'd1);
        chk("t6b done",  32'(Done),      32'd1);
        chk("t6b count", 32'(WordCount), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
